// File: rtl/pulse_player.sv
// pulse_player: plays per-channel pulse commands as envelope memory sweeps with aligned freq/phase/valid outputs
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   cstrobe_in                 one-cycle command strobe
//   freq_in, phase_in          frequency / phase words, valid with cstrobe_in
//   env_word_in                {length, start} envelope descriptor, valid with cstrobe_in
//   env_raddr, env_rden        envelope memory read address / enable
//   freq_out, phase_out        frequency / phase aligned to envelope read data
//   sample_valid, pulse_first  envelope data valid / first sample of a pulse
//   busy                       playing or a command is pending
//   overflow                   sticky: a command was dropped
module pulse_player #(
    parameter int FREQ_WORD_WIDTH  = 24,
    parameter int PHASE_WORD_WIDTH = 14,
    parameter int ENV_WORD_WIDTH   = 24,
    parameter int ENV_ADDR_WIDTH   = 12,
    parameter int ENV_LEN_WIDTH    = 12,
    parameter int MEM_LATENCY      = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cstrobe_in,
    input  logic [FREQ_WORD_WIDTH-1:0]  freq_in,
    input  logic [PHASE_WORD_WIDTH-1:0] phase_in,
    input  logic [ENV_WORD_WIDTH-1:0]   env_word_in,
    output logic [ENV_ADDR_WIDTH-1:0]   env_raddr,
    output logic                        env_rden,
    output logic [FREQ_WORD_WIDTH-1:0]  freq_out,
    output logic [PHASE_WORD_WIDTH-1:0] phase_out,
    output logic                        sample_valid,
    output logic                        pulse_first,
    output logic                        busy,
    output logic                        overflow
);
    typedef enum logic {IDLE, PLAY} state_t;

    state_t                      state_q, state_d;
    logic [FREQ_WORD_WIDTH-1:0]  act_freq_q, act_freq_d;
    logic [PHASE_WORD_WIDTH-1:0] act_phase_q, act_phase_d;
    logic [ENV_ADDR_WIDTH-1:0]   act_addr_q, act_addr_d;
    logic [ENV_LEN_WIDTH-1:0]    act_rem_q, act_rem_d;
    logic                        act_first_q, act_first_d;
    logic                        pend_valid_q, pend_valid_d;
    logic [FREQ_WORD_WIDTH-1:0]  pend_freq_q, pend_freq_d;
    logic [PHASE_WORD_WIDTH-1:0] pend_phase_q, pend_phase_d;
    logic [ENV_ADDR_WIDTH-1:0]   pend_start_q, pend_start_d;
    logic [ENV_LEN_WIDTH-1:0]    pend_len_q, pend_len_d;
    logic                        overflow_q, overflow_d;
    logic                        busy_q, busy_d;

    logic [ENV_LEN_WIDTH-1:0]    len_in;
    logic [ENV_ADDR_WIDTH-1:0]   start_in;
    logic                        cmd, play, last;

    assign len_in   = env_word_in[ENV_WORD_WIDTH-1 -: ENV_LEN_WIDTH];
    assign start_in = env_word_in[ENV_ADDR_WIDTH-1:0];
    // zero-length commands are ignored everywhere, including overflow accounting
    assign cmd      = cstrobe_in && (len_in != '0);
    assign play     = (state_q == PLAY);
    assign last     = play && (act_rem_q == ENV_LEN_WIDTH'(1));

    always_comb begin
        state_d      = state_q;
        act_freq_d   = act_freq_q;
        act_phase_d  = act_phase_q;
        act_addr_d   = act_addr_q;
        act_rem_d    = act_rem_q;
        act_first_d  = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_freq_d  = pend_freq_q;
        pend_phase_d = pend_phase_q;
        pend_start_d = pend_start_q;
        pend_len_d   = pend_len_q;
        overflow_d   = overflow_q;
        if (!play) begin
            if (cmd) begin
                state_d     = PLAY;
                act_freq_d  = freq_in;
                act_phase_d = phase_in;
                act_addr_d  = start_in;
                act_rem_d   = len_in;
                act_first_d = 1'b1;
            end
        end else if (last) begin
            if (pend_valid_q) begin
                act_freq_d   = pend_freq_q;
                act_phase_d  = pend_phase_q;
                act_addr_d   = pend_start_q;
                act_rem_d    = pend_len_q;
                act_first_d  = 1'b1;
                // the slot frees as it drains, so a simultaneous command refills it
                pend_valid_d = cmd;
                if (cmd) begin
                    pend_freq_d  = freq_in;
                    pend_phase_d = phase_in;
                    pend_start_d = start_in;
                    pend_len_d   = len_in;
                end
            end else if (cmd) begin
                act_freq_d  = freq_in;
                act_phase_d = phase_in;
                act_addr_d  = start_in;
                act_rem_d   = len_in;
                act_first_d = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            act_addr_d = act_addr_q + ENV_ADDR_WIDTH'(1);
            act_rem_d  = act_rem_q - ENV_LEN_WIDTH'(1);
            if (cmd && !pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_freq_d  = freq_in;
                pend_phase_d = phase_in;
                pend_start_d = start_in;
                pend_len_d   = len_in;
            end else if (cmd) begin
                overflow_d = 1'b1;
            end
        end
        busy_d = (state_d == PLAY) || pend_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            act_freq_q   <= '0;
            act_phase_q  <= '0;
            act_addr_q   <= '0;
            act_rem_q    <= '0;
            act_first_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_freq_q  <= '0;
            pend_phase_q <= '0;
            pend_start_q <= '0;
            pend_len_q   <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_freq_q   <= act_freq_d;
            act_phase_q  <= act_phase_d;
            act_addr_q   <= act_addr_d;
            act_rem_q    <= act_rem_d;
            act_first_q  <= act_first_d;
            pend_valid_q <= pend_valid_d;
            pend_freq_q  <= pend_freq_d;
            pend_phase_q <= pend_phase_d;
            pend_start_q <= pend_start_d;
            pend_len_q   <= pend_len_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
        end
    end

    assign env_rden  = play;
    assign env_raddr = play ? act_addr_q : '0;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

    // Delay line matching the memory read latency; index 0 of each chain is the live input.
    logic [MEM_LATENCY-1:0]      vld_q, fst_q;
    logic [FREQ_WORD_WIDTH-1:0]  frq_q [MEM_LATENCY];
    logic [PHASE_WORD_WIDTH-1:0] phs_q [MEM_LATENCY];
    logic [MEM_LATENCY:0]        vld_c, fst_c;
    logic [FREQ_WORD_WIDTH-1:0]  frq_c [MEM_LATENCY+1];
    logic [PHASE_WORD_WIDTH-1:0] phs_c [MEM_LATENCY+1];

    assign vld_c = {vld_q, env_rden};
    assign fst_c = {fst_q, act_first_q && play};

    always_comb begin
        frq_c[0] = act_freq_q;
        phs_c[0] = act_phase_q;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            frq_c[i+1] = frq_q[i];
            phs_c[i+1] = phs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            fst_q <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                frq_q[i] <= '0;
                phs_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_c[MEM_LATENCY-1:0];
            fst_q <= fst_c[MEM_LATENCY-1:0];
            // freq/phase advance only with a valid sample so the output holds between pulses
            for (int i = 0; i < MEM_LATENCY; i++) begin
                if (vld_c[i]) begin
                    frq_q[i] <= frq_c[i];
                    phs_q[i] <= phs_c[i];
                end
            end
        end
    end

    assign sample_valid = vld_q[MEM_LATENCY-1];
    assign pulse_first  = fst_q[MEM_LATENCY-1];
    assign freq_out     = frq_q[MEM_LATENCY-1];
    assign phase_out    = phs_q[MEM_LATENCY-1];
endmodule

// File: tb/tb_pulse_player.sv
// tb_pulse_player: directed self-checking bench for pulse_player
module tb_pulse_player;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cstrobe_in = 1'b0;
    logic [23:0] freq_in = '0;
    logic [13:0] phase_in = '0;
    logic [23:0] env_word_in = '0;
    logic [11:0] env_raddr;
    logic        env_rden;
    logic [23:0] freq_out;
    logic [13:0] phase_out;
    logic        sample_valid, pulse_first, busy, overflow;
    int          checks = 0;
    int          errors = 0;

    pulse_player dut (
        .clk(clk), .reset(reset), .cstrobe_in(cstrobe_in), .freq_in(freq_in),
        .phase_in(phase_in), .env_word_in(env_word_in), .env_raddr(env_raddr),
        .env_rden(env_rden), .freq_out(freq_out), .phase_out(phase_out),
        .sample_valid(sample_valid), .pulse_first(pulse_first), .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive a command for one cycle; returns one cycle after it was sampled
    task automatic go(input logic [11:0] s, input logic [11:0] l, input logic [23:0] f, input logic [13:0] p);
        cstrobe_in  = 1'b1;
        env_word_in = {l, s};
        freq_in     = f;
        phase_in    = p;
        step();
        cstrobe_in  = 1'b0;
    endtask

    task automatic zchk(input string tag);
        chk({tag, "_raddr"}, 32'(env_raddr), 32'h0);
        chk({tag, "_rden"}, 32'(env_rden), 32'h0);
        chk({tag, "_freq"}, 32'(freq_out), 32'h0);
        chk({tag, "_phase"}, 32'(phase_out), 32'h0);
        chk({tag, "_sv"}, 32'(sample_valid), 32'h0);
        chk({tag, "_pf"}, 32'(pulse_first), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] a;
        step();
        step();
        zchk("rst");
        reset = 1'b0;
        step();

        // single pulse: start 0x010, len 4
        go(12'h010, 12'd4, 24'h123456, 14'h0ABC);
        for (int k = 0; k < 6; k++) begin
            chk("s_rden", 32'(env_rden), 32'(k < 4));
            chk("s_busy", 32'(busy), 32'(k < 4));
            if (k < 4) chk("s_raddr", 32'(env_raddr), 32'h010 + 32'(k));
            chk("s_sv", 32'(sample_valid), 32'(k >= 2));
            chk("s_pf", 32'(pulse_first), 32'(k == 2));
            if (k >= 2) begin
                chk("s_freq", 32'(freq_out), 32'h123456);
                chk("s_phase", 32'(phase_out), 32'h0ABC);
            end
            step();
        end
        chk("s_sv_end", 32'(sample_valid), 32'h0);
        chk("s_freq_hold", 32'(freq_out), 32'h123456);

        // address wrap
        go(12'hFFE, 12'd4, 24'h000010, 14'h0010);
        for (int k = 0; k < 4; k++) begin
            a = 12'hFFE + 12'(k);
            chk("w_raddr", 32'(env_raddr), 32'(a));
            step();
        end
        chk("w_rden_off", 32'(env_rden), 32'h0);
        chk("w_ovf", 32'(overflow), 32'h0);
        repeat (4) step();

        // back-to-back through the pending slot
        go(12'h100, 12'd3, 24'hAAAAAA, 14'h0111);
        chk("b_a0", 32'(env_raddr), 32'h100);
        go(12'h200, 12'd2, 24'h000001, 14'h0222);
        chk("b_a1", 32'(env_raddr), 32'h101);
        step();
        chk("b_a2", 32'(env_raddr), 32'h102);
        chk("b_pfA", 32'(pulse_first), 32'h1);
        chk("b_freqA", 32'(freq_out), 32'hAAAAAA);
        step();
        chk("b_b0", 32'(env_raddr), 32'h200);
        chk("b_rden", 32'(env_rden), 32'h1);
        step();
        chk("b_b1", 32'(env_raddr), 32'h201);
        chk("b_pf_mid", 32'(pulse_first), 32'h0);
        chk("b_freq_last_A", 32'(freq_out), 32'hAAAAAA);
        step();
        chk("b_pfB", 32'(pulse_first), 32'h1);
        chk("b_freqB", 32'(freq_out), 32'h000001);
        chk("b_phaseB", 32'(phase_out), 32'h0222);
        chk("b_rden_off", 32'(env_rden), 32'h0);
        chk("b_busy_off", 32'(busy), 32'h0);
        step();
        chk("b_sv_tail", 32'(sample_valid), 32'h1);
        step();
        chk("b_sv_end", 32'(sample_valid), 32'h0);
        chk("b_ovf", 32'(overflow), 32'h0);
        repeat (2) step();

        // overflow: A len 8, B pending, C dropped
        go(12'h300, 12'd8, 24'h000300, 14'h0300);
        chk("o_ovf1", 32'(overflow), 32'h0);
        go(12'h400, 12'd2, 24'h000400, 14'h0400);
        chk("o_ovf2", 32'(overflow), 32'h0);
        go(12'h500, 12'd2, 24'h000500, 14'h0500);
        chk("o_ovf3", 32'(overflow), 32'h1);
        chk("o_a2", 32'(env_raddr), 32'h302);
        repeat (6) step();
        chk("o_b0", 32'(env_raddr), 32'h400);
        step();
        chk("o_b1", 32'(env_raddr), 32'h401);
        step();
        chk("o_no_c", 32'(env_rden), 32'h0);
        chk("o_busy", 32'(busy), 32'h0);
        chk("o_sticky", 32'(overflow), 32'h1);
        repeat (4) step();

        // reset in the middle of a len 10 pulse
        go(12'h700, 12'd10, 24'h000700, 14'h0700);
        step();
        reset = 1'b1;
        step();
        zchk("mr");
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("mr_sv", 32'(sample_valid), 32'h0);
            chk("mr_rden", 32'(env_rden), 32'h0);
        end

        // strobe on the last address cycle with pending empty
        go(12'h050, 12'd2, 24'h000050, 14'h0050);
        chk("l_a0", 32'(env_raddr), 32'h050);
        step();
        chk("l_a1", 32'(env_raddr), 32'h051);
        go(12'h060, 12'd2, 24'h000060, 14'h0060);
        chk("l_d0", 32'(env_raddr), 32'h060);
        chk("l_rden", 32'(env_rden), 32'h1);
        chk("l_pfA", 32'(pulse_first), 32'h1);
        step();
        chk("l_d1", 32'(env_raddr), 32'h061);
        step();
        chk("l_pfD", 32'(pulse_first), 32'h1);
        chk("l_phaseD", 32'(phase_out), 32'h0060);
        chk("l_rden_off", 32'(env_rden), 32'h0);
        repeat (4) step();

        // zero-length command in IDLE
        go(12'h080, 12'd0, 24'h000080, 14'h0080);
        chk("z_rden", 32'(env_rden), 32'h0);
        chk("z_busy", 32'(busy), 32'h0);
        repeat (3) step();
        chk("z_sv", 32'(sample_valid), 32'h0);
        chk("z_ovf", 32'(overflow), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_player.md
# pulse_player

Downstream of the processor core, this block consumes the per-channel pulse command (cstrobe, frequency word, phase word, envelope word) and plays the pulse out. It sweeps envelope memory read addresses, then presents frequency, phase and a sample-valid strobe aligned to envelope memory read data for the signal-generator element. A one-deep pending slot absorbs a command that arrives while a pulse is still playing, so back-to-back pulses play with no gap; a command that finds the slot full is dropped and flagged.

## Interface
- FREQ_WORD_WIDTH, 24, frequency word width
- PHASE_WORD_WIDTH, 14, phase word width
- ENV_WORD_WIDTH, 24, envelope word width; word = {length[ENV_LEN_WIDTH-1:0], start[ENV_ADDR_WIDTH-1:0]}
- ENV_ADDR_WIDTH, 12, envelope memory address width
- ENV_LEN_WIDTH, 12, envelope length field width; ENV_ADDR_WIDTH+ENV_LEN_WIDTH == ENV_WORD_WIDTH
- MEM_LATENCY, 2, envelope memory read latency in cycles (>=1)

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- cstrobe_in  in  1  command strobe from processor, one cycle per command
- freq_in  in  FREQ_WORD_WIDTH  frequency word, valid with cstrobe_in
- phase_in  in  PHASE_WORD_WIDTH  phase word, valid with cstrobe_in
- env_word_in  in  ENV_WORD_WIDTH  envelope start/length, valid with cstrobe_in
- env_raddr  out  ENV_ADDR_WIDTH  envelope memory read address
- env_rden  out  1  envelope memory read enable
- freq_out  out  FREQ_WORD_WIDTH  frequency, aligned to envelope data
- phase_out  out  PHASE_WORD_WIDTH  phase, aligned to envelope data
- sample_valid  out  1  envelope memory data valid for this sample
- pulse_first  out  1  high with the first sample_valid of each pulse
- busy  out  1  high in PLAY or when the pending slot is full
- overflow  out  1  sticky; a command was dropped

## Operation
- States: IDLE, PLAY. Registers: active {freq, phase, addr, remaining}, pending {valid, freq, phase, start, len}.
- IDLE + cstrobe_in with len>0: load active from the inputs, go to PLAY. A command with len==0 is ignored: no pulse, no overflow.
- PLAY: each cycle assert env_rden with env_raddr = active addr. Address then increments modulo 2^ENV_ADDR_WIDTH and wraps with no error. remaining decrements.
- Last address cycle (remaining==1):
  - If pending is valid, load active from pending next cycle, clear pending, stay in PLAY with no gap.
  - Otherwise, if cstrobe_in (len>0) arrives this cycle, load it directly and stay in PLAY.
  - Otherwise go to IDLE.
- cstrobe_in (len>0) in PLAY, not the last cycle:
  - Pending empty: store the command in pending.
  - Pending full: drop the command and set overflow.
- Last cycle with pending full and cstrobe_in: pending moves to active and the new command enters pending; nothing is dropped.
- Output pipeline: {env_rden, first-address flag, active freq, active phase} delayed MEM_LATENCY cycles gives {sample_valid, pulse_first, freq_out, phase_out}.
- overflow clears only on reset.

## Timing
- Reset values: all outputs 0; state IDLE; pending invalid; output pipeline flushed.
- Reset mid-pulse aborts the pulse. No sample_valid appears after reset deasserts until a new command arrives.
- Command accepted in cycle t, IDLE, length L:
  - env_rden high for cycles t+1..t+L.
  - env_raddr = start+k in cycle t+1+k.
  - sample_valid high for t+1+MEM_LATENCY..t+L+MEM_LATENCY.
  - pulse_first at t+1+MEM_LATENCY.
- freq_out/phase_out update only when sample_valid is high and hold their last value otherwise.
- Back-to-back: if pulse A's last address is in cycle n, pulse B's first address is in cycle n+1. pulse_first marks B's first sample.
- busy is registered and reflects state after the current edge. busy goes low the cycle after the last address when nothing is pending.
- overflow rises the cycle after the dropping strobe.

## Test plan
- Single pulse: reset, then strobe at t with start=0x010, len=4, freq=0x123456, phase=0x0ABC.
  - Required: env_raddr 0x010..0x013 at t+1..t+4.
  - Required (MEM_LATENCY=2): sample_valid at t+3..t+6, pulse_first at t+3, freq_out=0x123456.
- Wrap: start=0xFFE, len=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001, no overflow.
- Back-to-back via pending:
  - Stimulus: A (start 0x100, len 3) at t; B (start 0x200, len 2, freq 0x000001) at t+1.
  - Required: addresses 0x100, 0x101, 0x102, 0x200, 0x201 at t+1..t+5, contiguous.
  - Required: freq_out switches on B's pulse_first at t+6.
- Overflow: A len 8 at t, B at t+1, C at t+2 -> C dropped; overflow=1 from t+3 and sticky; B plays after A.
- Strobe on the last address cycle with pending empty -> new pulse starts the next cycle with no gap. A len==0 strobe in IDLE -> no env_rden, busy stays 0.
- Reset asserted at t+2 of a len=10 pulse -> from the next edge all outputs are 0 and overflow=0; no residual sample_valid after reset deasserts.
